// File: rtl/fb_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// ALU results win the port and are written the cycle after they arrive.
// LSU results wait in a small FIFO and drain in cycles the ALU leaves free.
// An ALU write to rd R kills every queued live LSU entry for R, because the
// ALU result is always the younger value. Dead entries still hold their slot
// and pop without writing.
// The forwarding lookup returns the youngest live queued LSU value for fwd_rs.
module fb_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [4:0]               lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    input  logic [4:0]               fwd_rs,
    output logic                     fwd_hit,
    output logic [XLEN-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0]   pend_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      ent_rd   [DEPTH];
    logic [XLEN-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0] ent_live;
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [AW-1:0]   fwd_idx;

    logic alu_req;
    logic pop;
    logic push;

    // An ALU write to x0 is treated as no request at all, so the FIFO may drain.
    assign alu_req   = alu_valid && (alu_rd != 5'd0);
    assign pop       = !alu_req && (count != '0);
    // Ready depends only on registered occupancy, so a pop cannot raise it in the same cycle.
    assign lsu_ready = reset && (count < CW'(DEPTH));
    // LSU results for x0 complete the handshake but are never enqueued.
    assign push      = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    assign pend_cnt  = count;

    // Register the selected write; on a dead pop or an idle cycle the address and data hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= '0;
        end else if (alu_req) begin
            rf_we    <= 1'b1;
            rf_waddr <= alu_rd;
            rf_wdata <= alu_data;
        end else if (pop && ent_live[head]) begin
            rf_we    <= 1'b1;
            rf_waddr <= ent_rd[head];
            rf_wdata <= ent_data[head];
        end else begin
            rf_we    <= 1'b0;
        end
    end

    // Pointers, occupancy and liveness. The kill is applied before the push, so an
    // entry enqueued alongside an ALU write to the same rd stays live.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ent_live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_req && (ent_rd[i] == alu_rd)) begin
                    ent_live[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_live[head] <= 1'b0;
                head           <= head + 1'b1;
            end
            if (push) begin
                ent_live[tail] <= 1'b1;
                tail           <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage. Entry contents only matter while the live bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_rd[tail]   <= lsu_rd;
            ent_data[tail] <= lsu_data;
        end
    end

    // Scan from oldest to youngest; the last match wins, which gives the youngest live value.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (fwd_rs != 5'd0) begin
            for (int k = 0; k < DEPTH; k++) begin
                fwd_idx = head + AW'(k);
                if ((CW'(k) < count) && ent_live[fwd_idx] && (ent_rd[fwd_idx] == fwd_rs)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = ent_data[fwd_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_fb_wb_arbiter.sv
// Bench for fb_wb_arbiter. A queue-based reference model predicts every output.
// A hand-derived vector table, hand-written corner sequences and a randomized run
// are all checked against it.
module tb_fb_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [4:0]      fwd_rs;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    logic [CW-1:0]   pend_cnt;

    fb_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .fwd_rs    (fwd_rs),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO as a queue of entries in age order, oldest first.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    bit          m_valid = 1'b0;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic void model_fwd(input logic [4:0] rs, output bit hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (rs != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].live && mq[i].rd == rs) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                    break;
                end
            end
        end
    endfunction

    // One clock: check combinational outputs, advance the model, then check registered outputs.
    task automatic tick();
        bit          hit;
        logic [31:0] d;
        bit          rdy;
        bit          rst_now;
        ent_t        e;
        #1;
        if (m_valid) begin
            model_fwd(fwd_rs, hit, d);
            chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, reset && (mq.size() < DEPTH)});
            chk("pend_cnt", 32'(pend_cnt), 32'(mq.size()));
            chk("fwd_hit", {31'd0, fwd_hit}, {31'd0, hit});
            chk("fwd_data", fwd_data, d);
        end
        rst_now = !reset;
        if (rst_now) begin
            mq.delete();
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            rdy  = (mq.size() < DEPTH);
            m_we = 1'b0;
            if (alu_valid && alu_rd != 5'd0) begin
                m_we    = 1'b1;
                m_waddr = alu_rd;
                m_wdata = alu_data;
                foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].live = 1'b0;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                if (e.live) begin
                    m_we    = 1'b1;
                    m_waddr = e.rd;
                    m_wdata = e.data;
                end
            end
            if (lsu_valid && rdy && lsu_rd != 5'd0)
                mq.push_back('{rd: lsu_rd, data: lsu_data, live: 1'b1});
        end
        @(posedge clk);
        #1;
        if (m_valid) begin
            chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
            if (m_we || rst_now) begin
                chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
                chk("rf_wdata", rf_wdata, m_wdata);
            end
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld, input logic [4:0] rs);
        reset = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; fwd_rs = rs;
    endtask

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic        erdy;
        int          epend;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int          acc;
        int          dut_acc;
        logic [4:0]  wr_a[$];
        logic [31:0] wr_d[$];

        // rst av ard ad | lv lrd ld | we waddr wdata ready pend  (sampled after the edge)
        vecs = '{
            '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hDEAD, 1'b0, 5'd0, 32'h0,    1'b0, 0},
            '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hDEAD, 1'b0, 5'd0, 32'h0,    1'b0, 0},
            '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hDEAD, 1'b0, 5'd0, 32'h0,    1'b0, 0},
            '{1'b1, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 0},
            '{1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'h1234, 1'b1, 0},
            '{1'b1, 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'h1234, 1'b1, 0},
            '{1'b1, 1'b1, 5'd3, 32'hA,    1'b1, 5'd7, 32'hB,    1'b1, 5'd3, 32'hA,    1'b1, 1},
            '{1'b1, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hB,    1'b1, 0},
            '{1'b1, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd7, 32'hB,    1'b1, 0},
            '{1'b1, 1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h77,   1'b0, 5'd7, 32'hB,    1'b1, 0},
            '{1'b1, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd7, 32'hB,    1'b1, 0}
        };

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld, 5'd0);
            tick();
            chk($sformatf("vec%0d_we", i), {31'd0, rf_we}, {31'd0, vecs[i].ewe});
            chk($sformatf("vec%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].ewa});
            chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].ewd);
            chk($sformatf("vec%0d_ready", i), {31'd0, lsu_ready}, {31'd0, vecs[i].erdy});
            chk($sformatf("vec%0d_pend", i), 32'(pend_cnt), 32'(vecs[i].epend));
        end

        // Full FIFO under continuous ALU traffic, then drain in order across a pointer wrap.
        acc = 0;
        dut_acc = 0;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'h100 + i, (acc < 3), 5'(10 + acc), 32'hB0 + acc, 5'd0);
            #1;
            if (lsu_valid && lsu_ready) dut_acc++;
            if (lsu_valid && mq.size() < DEPTH) acc++;
            tick();
        end
        chk("t4_accepted_under_alu", 32'(dut_acc), 32'd2);
        for (int c = 0; c < 20 && (acc < 3 || mq.size() > 0); c++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, (acc < 3), 5'(10 + acc), 32'hB0 + acc, 5'd0);
            if (lsu_valid && mq.size() < DEPTH) acc++;
            tick();
            if (rf_we) begin
                wr_a.push_back(rf_waddr);
                wr_d.push_back(rf_wdata);
            end
        end
        chk("t4_nwrites", 32'(wr_a.size()), 32'd3);
        for (int k = 0; k < 3 && k < wr_a.size(); k++) begin
            chk($sformatf("t4_waddr%0d", k), {27'd0, wr_a[k]}, 32'd10 + k);
            chk($sformatf("t4_wdata%0d", k), wr_d[k], 32'hB0 + k);
        end

        // Queued LSU x9 killed by a younger ALU write to x9.
        drive(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99, 5'd9);
        tick();
        drive(1'b1, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0, 5'd9);
        #1;
        chk("t5_hit_before_kill", {31'd0, fwd_hit}, 32'd1);
        chk("t5_data_before_kill", fwd_data, 32'h99);
        tick();
        chk("t5_alu_we", {31'd0, rf_we}, 32'd1);
        chk("t5_alu_waddr", {27'd0, rf_waddr}, 32'd9);
        chk("t5_alu_wdata", rf_wdata, 32'h55);
        chk("t5_hit_after_kill", {31'd0, fwd_hit}, 32'd0);
        chk("t5_pend_dead", 32'(pend_cnt), 32'd1);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9);
        tick();
        chk("t5_dead_pop_we", {31'd0, rf_we}, 32'd0);
        chk("t5_dead_pop_pend", 32'(pend_cnt), 32'd0);

        // Two queued x4 results: forwarding returns the younger one.
        drive(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd4, 32'h40, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd4, 32'h41, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'h0, 5'd4);
        #1;
        chk("t6_hit_rs4", {31'd0, fwd_hit}, 32'd1);
        chk("t6_data_rs4", fwd_data, 32'h41);
        fwd_rs = 5'd0;
        #1;
        chk("t6_hit_rs0", {31'd0, fwd_hit}, 32'd0);
        chk("t6_data_rs0", fwd_data, 32'h0);
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd4);
            tick();
        end

        // Randomized traffic with narrow rd range to force collisions and kills.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
